arcade_input_mapper: RTL

ARCADE_INPUT_MAPPER -- requirements
Module: arcade_input_mapper

---
 rtl/arcade_input_mapper.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/arcade_input_mapper.sv
// Arcade control mapper: merges PS/2 key events and joystick words into per-player
// direction/button/start/coin outputs with SOCD cleaning, autofire and coin pulses.
module arcade_input_mapper #(
  parameter int unsigned NUM_PLAYERS  = 2,
  parameter int unsigned COIN_CYCLES  = 120000,
  parameter int unsigned AUTOFIRE_DIV = 400000,
  parameter bit          SHARED_MODE  = 1'b0
) (
  input  logic                      clk_sys,
  input  logic                      reset_n,
  input  logic [10:0]               ps2_key,
  input  logic [32*NUM_PLAYERS-1:0] joy_in,
  input  logic [7:0]                autofire_en,
  input  logic [1:0]                socd_mode,
  output logic [4*NUM_PLAYERS-1:0]  dir_out,
  output logic [8*NUM_PLAYERS-1:0]  btn_out,
  output logic [NUM_PLAYERS-1:0]    start_out,
  output logic [NUM_PLAYERS-1:0]    coin_out,
  output logic                      key_event
);

  localparam int unsigned NP = NUM_PLAYERS;
  localparam int unsigned AW = $clog2(AUTOFIRE_DIV);
  localparam int unsigned CW = $clog2(COIN_CYCLES + 1);

  typedef enum logic [1:0] {
    SOCD_PASS    = 2'b00,
    SOCD_LAST    = 2'b01,
    SOCD_NEUTRAL = 2'b10,
    SOCD_PASS_B  = 2'b11
  } socd_e;

  // keys: [7:0] dirs P1/P2, [15:8] buttons A-D P1/P2, [19:16] start1-4, [23:20] coin1-4
  logic [23:0]        keys;
  logic [4:0]         key_idx;
  logic [1:0]         key_plr;
  logic               key_hit;
  logic               ps2_copy, primed, ps2_evt;

  logic [4*NP-1:0]    joy_dir_r, raw_dir, mix_dir, dir_prev, dir_next;
  logic [8*NP-1:0]    joy_btn_r, raw_btn, mix_btn, btn_prev, btn_next;
  logic [8*NP-1:0]    phase, phase_next;
  logic [NP-1:0]      joy_start_r, joy_coin_r, raw_start, raw_coin, coin_prev;
  logic [2*NP-1:0]    hist, hist_next;
  logic [AW-1:0]      af_cnt;
  logic               af_tick;
  logic [CW-1:0]      coin_cnt [NP];
  logic               unused_bits;

  always_comb begin
    key_hit = 1'b1;
    key_idx = '0;
    key_plr = '0;
    case ({ps2_key[8], ps2_key[7:0]})
      9'h175:         key_idx = 5'd3;
      9'h172:         key_idx = 5'd2;
      9'h16B:         key_idx = 5'd1;
      9'h174:         key_idx = 5'd0;
      9'h014:         key_idx = 5'd8;
      9'h011:         key_idx = 5'd9;
      9'h029:         key_idx = 5'd10;
      9'h012:         key_idx = 5'd11;
      9'h005, 9'h016: key_idx = 5'd16;
      9'h006, 9'h01E: begin key_idx = 5'd17; key_plr = 2'd1; end
      9'h004, 9'h026: begin key_idx = 5'd18; key_plr = 2'd2; end
      9'h00C, 9'h025: begin key_idx = 5'd19; key_plr = 2'd3; end
      9'h076, 9'h02E: key_idx = 5'd20;
      9'h036:         begin key_idx = 5'd21; key_plr = 2'd1; end
      9'h03D:         begin key_idx = 5'd22; key_plr = 2'd2; end
      9'h03E:         begin key_idx = 5'd23; key_plr = 2'd3; end
      9'h02D:         begin key_idx = 5'd7;  key_plr = 2'd1; end
      9'h02B:         begin key_idx = 5'd6;  key_plr = 2'd1; end
      9'h023:         begin key_idx = 5'd5;  key_plr = 2'd1; end
      9'h034:         begin key_idx = 5'd4;  key_plr = 2'd1; end
      9'h01C:         begin key_idx = 5'd12; key_plr = 2'd1; end
      9'h01B:         begin key_idx = 5'd13; key_plr = 2'd1; end
      9'h021:         begin key_idx = 5'd14; key_plr = 2'd1; end
      9'h01D:         begin key_idx = 5'd15; key_plr = 2'd1; end
      default:        key_hit = 1'b0;
    endcase
  end

  assign ps2_evt = primed & (ps2_key[10] ^ ps2_copy);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ps2_copy  <= 1'b0;
      primed    <= 1'b0;
      key_event <= 1'b0;
      keys      <= '0;
    end else begin
      ps2_copy  <= ps2_key[10];
      primed    <= 1'b1;
      key_event <= ps2_evt;
      if (ps2_evt && key_hit && (32'(key_plr) < NP))
        keys[key_idx] <= ps2_key[9];
    end
  end

  always_comb begin
    raw_dir   = '0;
    raw_btn   = '0;
    raw_start = '0;
    raw_coin  = '0;
    for (int unsigned p = 0; p < NP; p++) begin
      raw_dir[4*p +: 4] = joy_dir_r[4*p +: 4];
      raw_btn[8*p +: 8] = joy_btn_r[8*p +: 8];
      raw_start[p]      = joy_start_r[p] | keys[16+p];
      raw_coin[p]       = joy_coin_r[p] | keys[20+p];
      if (p < 2) begin
        raw_dir[4*p +: 4] = raw_dir[4*p +: 4] | keys[4*p +: 4];
        raw_btn[8*p +: 4] = raw_btn[8*p +: 4] | keys[8+4*p +: 4];
      end
    end
    mix_dir = raw_dir;
    mix_btn = raw_btn;
    if (SHARED_MODE) begin
      mix_dir = '0;
      mix_btn = '0;
      for (int unsigned p = 0; p < NP; p++) begin
        mix_dir[3:0] = mix_dir[3:0] | raw_dir[4*p +: 4];
        mix_btn[7:0] = mix_btn[7:0] | raw_btn[8*p +: 8];
      end
    end
  end

  // Pair q of player p: member a is R (q=0) or D (q=1), member b is L or U.
  // hist bit set means member b was the most recent to rise; simultaneous rises favour a.
  always_comb begin
    hist_next = hist;
    dir_next  = mix_dir;
    for (int unsigned p = 0; p < NP; p++) begin
      for (int unsigned q = 0; q < 2; q++) begin
        if (mix_dir[4*p+2*q] && !dir_prev[4*p+2*q])
          hist_next[2*p+q] = 1'b0;
        else if (mix_dir[4*p+2*q+1] && !dir_prev[4*p+2*q+1])
          hist_next[2*p+q] = 1'b1;
        if (mix_dir[4*p+2*q] && mix_dir[4*p+2*q+1]) begin
          case (socd_e'(socd_mode))
            SOCD_LAST: begin
              dir_next[4*p+2*q]   = ~hist_next[2*p+q];
              dir_next[4*p+2*q+1] = hist_next[2*p+q];
            end
            SOCD_NEUTRAL: begin
              dir_next[4*p+2*q]   = 1'b0;
              dir_next[4*p+2*q+1] = 1'b0;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign af_tick = (af_cnt == AW'(AUTOFIRE_DIV - 1));

  always_comb begin
    phase_next = phase;
    btn_next   = mix_btn;
    for (int unsigned i = 0; i < 8*NP; i++) begin
      if (mix_btn[i] && !btn_prev[i])
        phase_next[i] = 1'b1;
      else if (mix_btn[i] && af_tick)
        phase_next[i] = ~phase[i];
      if (autofire_en[i % 8])
        btn_next[i] = mix_btn[i] & phase_next[i];
    end
  end

  always_comb begin
    unused_bits = 1'b0;
    for (int unsigned p = 0; p < NP; p++)
      unused_bits = unused_bits ^ (^joy_in[32*p+14 +: 18]);
    for (int unsigned p = NP; p < 4; p++) begin
      unused_bits = unused_bits ^ keys[16+p] ^ keys[20+p];
      if (p < 2)
        unused_bits = unused_bits ^ (^keys[4*p +: 4]) ^ (^keys[8+4*p +: 4]);
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      joy_dir_r   <= '0;
      joy_btn_r   <= '0;
      joy_start_r <= '0;
      joy_coin_r  <= '0;
      dir_prev    <= '0;
      btn_prev    <= '0;
      coin_prev   <= '0;
      hist        <= '0;
      phase       <= '0;
      af_cnt      <= '0;
      dir_out     <= '0;
      btn_out     <= '0;
      start_out   <= '0;
      coin_out    <= '0;
      for (int unsigned p = 0; p < NP; p++)
        coin_cnt[p] <= '0;
    end else begin
      for (int unsigned p = 0; p < NP; p++) begin
        joy_dir_r[4*p +: 4] <= joy_in[32*p +: 4];
        joy_btn_r[8*p +: 8] <= joy_in[32*p+4 +: 8];
        joy_start_r[p]      <= joy_in[32*p+12];
        joy_coin_r[p]       <= joy_in[32*p+13];
        // A rise is accepted only while idle; coin_out drops on the cycle the count leaves 1.
        if (coin_cnt[p] == '0) begin
          if (raw_coin[p] && !coin_prev[p]) begin
            coin_cnt[p] <= CW'(COIN_CYCLES);
            coin_out[p] <= 1'b1;
          end else begin
            coin_out[p] <= 1'b0;
          end
        end else begin
          coin_cnt[p] <= coin_cnt[p] - CW'(1);
          coin_out[p] <= (coin_cnt[p] != CW'(1));
        end
      end
      dir_prev  <= mix_dir;
      btn_prev  <= mix_btn;
      coin_prev <= raw_coin;
      hist      <= hist_next;
      phase     <= phase_next;
      af_cnt    <= af_tick ? '0 : af_cnt + AW'(1);
      dir_out   <= dir_next;
      btn_out   <= btn_next;
      start_out <= raw_start;
    end
  end

endmodule
